// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side checker for the 8-bit PRBS produced by the lfsr generator
//   (next(w) = {w[6:0], w[7]^w[5]^w[4]^w[3]}). While hunting it seeds a
//   prediction from the incoming words and declares lock after LOCK_MATCHES
//   consecutive correct predictions. Once locked, the prediction free-runs, so
//   isolated corrupted words never disturb it. Mismatches while locked are
//   pulsed on error_o and counted in a saturating counter. UNLOCK_ERRORS
//   consecutive mismatches drop lock and restart the hunt.
//
// Ports
//   clk_i        in   1      clock, all logic on posedge
//   rst_i        in   1      asynchronous reset, active-high
//   valid_i      in   1      data_i carries a new PRBS word this cycle
//   data_i       in   8      received PRBS word
//   clear_i      in   1      synchronous clear of err_count_o
//   locked_o     out  1      checker is locked to the sequence
//   error_o      out  1      one-cycle pulse: last valid word mismatched while locked
//   err_count_o  out  CNT_W  saturating count of mismatches while locked
// -----------------------------------------------------------------------------
module lfsr_checker #(
   parameter int LOCK_MATCHES  = 4,
   parameter int UNLOCK_ERRORS = 3,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [7:0]       data_i,
   input  logic             clear_i,
   output logic             locked_o,
   output logic             error_o,
   output logic [CNT_W-1:0] err_count_o
);

   localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
   localparam int MISS_W  = $clog2(UNLOCK_ERRORS + 1);

   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_ERRORS);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // One step of the PRBS recurrence.
   function automatic logic [7:0] prbs_next(input logic [7:0] w);
      return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t             state, state_nxt;
   logic               have_ref, have_ref_nxt;
   logic [7:0]         exp, exp_nxt;
   logic [MATCH_W-1:0] match_cnt, match_cnt_nxt;
   logic [MISS_W-1:0]  miss_cnt, miss_cnt_nxt;
   logic               error_nxt;
   logic               cnt_inc;

   logic               word_ok;
   logic [MATCH_W-1:0] match_inc;
   logic [MISS_W-1:0]  miss_inc;

   assign word_ok   = (data_i == exp);
   assign match_inc = match_cnt + MATCH_W'(1);
   assign miss_inc  = miss_cnt + MISS_W'(1);

   // State and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= HUNT;
         have_ref  <= 1'b0;
         exp       <= 8'h00;
         match_cnt <= '0;
         miss_cnt  <= '0;
         error_o   <= 1'b0;
      end else begin
         state     <= state_nxt;
         have_ref  <= have_ref_nxt;
         exp       <= exp_nxt;
         match_cnt <= match_cnt_nxt;
         miss_cnt  <= miss_cnt_nxt;
         error_o   <= error_nxt;
      end
   end

   // Next-state and datapath decisions
   always_comb begin
      state_nxt     = state;
      have_ref_nxt  = have_ref;
      exp_nxt       = exp;
      match_cnt_nxt = match_cnt;
      miss_cnt_nxt  = miss_cnt;
      error_nxt     = 1'b0;
      cnt_inc       = 1'b0;

      if (valid_i) begin
         unique case (state)
            HUNT: begin
               if (data_i == 8'h00) begin
                  // All-zero is the LFSR lockup word; it can never seed a
                  // valid prediction, so drop whatever reference we had.
                  have_ref_nxt  = 1'b0;
                  match_cnt_nxt = '0;
               end else if (!have_ref) begin
                  exp_nxt       = prbs_next(data_i);
                  have_ref_nxt  = 1'b1;
                  match_cnt_nxt = '0;
               end else if (word_ok) begin
                  exp_nxt       = prbs_next(data_i);
                  match_cnt_nxt = match_inc;
                  if (match_inc == MATCH_LAST) begin
                     state_nxt    = LOCKED;
                     miss_cnt_nxt = '0;
                  end
               end else begin
                  // Reseed from the word just received.
                  exp_nxt       = prbs_next(data_i);
                  match_cnt_nxt = '0;
               end
            end

            LOCKED: begin
               // Prediction advances on its own; the received word is only
               // compared, never used to reseed.
               exp_nxt = prbs_next(exp);
               if (word_ok) begin
                  miss_cnt_nxt = '0;
               end else begin
                  error_nxt    = 1'b1;
                  cnt_inc      = 1'b1;
                  miss_cnt_nxt = miss_inc;
                  if (miss_inc == MISS_LAST) begin
                     state_nxt     = HUNT;
                     have_ref_nxt  = 1'b0;
                     match_cnt_nxt = '0;
                  end
               end
            end

            default: begin
               state_nxt = HUNT;
            end
         endcase
      end
   end

   // Error counter; a clear in the same cycle as an increment wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_count_o <= '0;
      end else if (clear_i) begin
         err_count_o <= '0;
      end else if (cnt_inc) begin
         err_count_o <= sat_inc(err_count_o);
      end
   end

   assign locked_o = (state == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] data;
   logic       clear;

   logic        locked1, error1;
   logic [15:0] count1;
   logic        locked2, error2;
   logic [1:0]  count2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Default configuration.
   lfsr_checker #(.LOCK_MATCHES(4), .UNLOCK_ERRORS(3), .CNT_W(16)) dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .clear_i(clear),
      .locked_o(locked1), .error_o(error1), .err_count_o(count1)
   );

   // Narrow counter, tolerant unlock: exercises saturation.
   lfsr_checker #(.LOCK_MATCHES(4), .UNLOCK_ERRORS(8), .CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data), .clear_i(clear),
      .locked_o(locked2), .error_o(error2), .err_count_o(count2)
   );

   typedef struct packed {
      logic       locked;
      logic       have;
      logic       err;
      logic [7:0] exp;
      int         mc;
      int         ms;
      int         cnt;
   } model_t;

   model_t m1, m2;

   // PRBS step written as shift plus parity of the tap mask.
   function automatic logic [7:0] nx(input logic [7:0] w);
      logic [7:0] s;
      s = w << 1;
      s[0] = ^(w & 8'hB8);
      return s;
   endfunction

   function automatic model_t step(input model_t m, input logic v, input logic [7:0] d,
                                   input logic clr, input int lockm, input int unlk,
                                   input int cmax);
      model_t n;
      n = m;
      n.err = 1'b0;
      if (v) begin
         if (!m.locked) begin
            if (d == 8'h00) begin
               n.have = 1'b0;
               n.mc   = 0;
            end else if (!m.have) begin
               n.exp  = nx(d);
               n.have = 1'b1;
               n.mc   = 0;
            end else if (d == m.exp) begin
               n.exp = nx(d);
               n.mc  = m.mc + 1;
               if (n.mc == lockm) begin
                  n.locked = 1'b1;
                  n.ms     = 0;
               end
            end else begin
               n.exp = nx(d);
               n.mc  = 0;
            end
         end else begin
            n.exp = nx(m.exp);
            if (d == m.exp) begin
               n.ms = 0;
            end else begin
               n.err = 1'b1;
               if (m.cnt < cmax) n.cnt = m.cnt + 1;
               n.ms = m.ms + 1;
               if (n.ms == unlk) begin
                  n.locked = 1'b0;
                  n.have   = 1'b0;
                  n.mc     = 0;
               end
            end
         end
      end
      if (clr) n.cnt = 0;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic compare_all();
      chk("locked1", 32'(locked1), 32'(m1.locked));
      chk("error1",  32'(error1),  32'(m1.err));
      chk("count1",  32'(count1),  32'(m1.cnt));
      chk("locked2", 32'(locked2), 32'(m2.locked));
      chk("error2",  32'(error2),  32'(m2.err));
      chk("count2",  32'(count2),  32'(m2.cnt));
   endtask

   task automatic tick(input logic v, input logic [7:0] d, input logic c);
      valid = v;
      data  = d;
      clear = c;
      @(posedge clk);
      m1 = step(m1, v, d, c, 4, 3, 65535);
      m2 = step(m2, v, d, c, 4, 8, 3);
      #1;
      compare_all();
   endtask

   // Asynchronous reset pulse between clock edges, with valid held high.
   task automatic pulse_reset();
      valid = 1'b1;
      data  = 8'h5A;
      rst   = 1'b1;
      #1;
      m1 = '0;
      m2 = '0;
      chk("rst_locked_now", 32'(locked1), 32'd0);
      chk("rst_count_now",  32'(count1),  32'd0);
      compare_all();
      #1;
      rst = 1'b0;
   endtask

   logic [7:0] g;
   logic [7:0] w;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      clear = 1'b0;
      m1    = '0;
      m2    = '0;
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("reset_locked", 32'(locked1), 32'd0);
      chk("reset_count",  32'(count1),  32'd0);
      rst = 1'b0;

      // Lock on AA,55,AB,57,AF.
      tick(1, 8'hAA, 0);
      tick(1, 8'h55, 0);
      tick(1, 8'hAB, 0);
      tick(1, 8'h57, 0);
      chk("lock_not_yet", 32'(locked1), 32'd0);
      tick(1, 8'hAF, 0);
      chk("lock_locked", 32'(locked1), 32'd1);
      chk("lock_error",  32'(error1),  32'd0);
      chk("lock_count",  32'(count1),  32'd0);

      // Single corrupted word: prediction keeps running.
      w = nx(8'hAF);
      tick(1, w ^ 8'h01, 0);
      chk("single_err_pulse", 32'(error1),  32'd1);
      chk("single_err_count", 32'(count1),  32'd1);
      w = nx(w);
      tick(1, w, 0);
      chk("single_err_clear", 32'(error1),  32'd0);
      w = nx(w);
      tick(1, w, 0);
      chk("single_err_lock",  32'(locked1), 32'd1);
      chk("single_err_hold",  32'(count1),  32'd1);

      // Clear on an idle cycle, then three wrong words unlock.
      tick(0, 8'h00, 1);
      chk("clear_idle", 32'(count1), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick(1, 8'h00, 0);
         chk("unlock_pulse", 32'(error1), 32'd1);
      end
      chk("unlock_count",  32'(count1),  32'd3);
      chk("unlock_locked", 32'(locked1), 32'd0);
      tick(1, 8'hAA, 0);
      tick(1, 8'h55, 0);
      tick(1, 8'hAB, 0);
      tick(1, 8'h57, 0);
      tick(1, 8'hAF, 0);
      chk("relock", 32'(locked1), 32'd1);

      // Hunt reseed: 12 breaks the run, its successors then lock.
      pulse_reset();
      tick(1, 8'hAA, 0);
      tick(1, 8'h55, 0);
      tick(1, 8'h12, 0);
      chk("reseed_no_err", 32'(error1), 32'd0);
      w = 8'h12;
      for (int i = 0; i < 4; i++) begin
         chk("reseed_unlocked", 32'(locked1), 32'd0);
         w = nx(w);
         tick(1, w, 0);
         chk("reseed_no_err", 32'(error1), 32'd0);
      end
      chk("reseed_locked", 32'(locked1), 32'd1);

      // Saturation on the 2-bit counter, then clear beating an increment.
      for (int i = 0; i < 5; i++) tick(1, 8'h00, 0);
      chk("sat_count",  32'(count2),  32'd3);
      chk("sat_locked", 32'(locked2), 32'd1);
      tick(1, 8'h00, 1);
      chk("clear_wins_count", 32'(count2), 32'd0);
      chk("clear_wins_pulse", 32'(error2), 32'd1);

      // Randomised stream with gaps, corruptions, clears and resets.
      g = 8'hA5;
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 5) begin
            pulse_reset();
         end else if (r < 15) begin
            g = 8'($urandom_range(1, 255));
         end else if (r < 215) begin
            tick(0, 8'($urandom), ($urandom_range(0, 29) == 0));
         end else begin
            logic c;
            c = ($urandom_range(0, 29) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 85)      tick(1, g, c);
            else if (r < 95) tick(1, g ^ 8'($urandom_range(1, 255)), c);
            else             tick(1, 8'h00, c);
            g = nx(g);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
